apb_master_mslv: RTL and testbench
==================================

Name: apb_master_mslv

Overview:
Parametrised second-generation APB3 master bridge. It accepts single-transfer commands (TRANSFER, READ_WRITE, PWADDR, PRADDR, PWDATA) from the test or system side and drives a shared APB bus to NUM_SLV slaves. The slave is decoded from the address MSBs. Supports PREADY wait states, per-slave PSLVERR and back-to-back transfers. It returns read data on DATA_OUT and status on PSLVERR.

Parameters:
ADDR_W, 9, command and bus address width
DATA_W, 8, data width
NUM_SLV, 2, number of APB slaves (1..8); select = PADDR[ADDR_W-1 -: SEL_W], SEL_W = max(1, clog2(NUM_SLV))
TIMEOUT, 16, ACCESS-phase wait limit in cycles (used only with APB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all logic on posedge
PRESETn  in  1  synchronous active-low reset
TRANSFER  in  1  command request
READ_WRITE  in  1  1=read, 0=write
PWADDR  in  ADDR_W  write address
PRADDR  in  ADDR_W  read address
PWDATA  in  DATA_W  write data
cmd_ready  out  1  command accepted this cycle when TRANSFER=1
DATA_OUT  out  DATA_W  last successful read data
PSLVERR  out  1  error status of last completed transfer
done  out  1  one-cycle completion pulse
PADDR  out  ADDR_W  bus address
PSEL  out  NUM_SLV  one-hot slave select
PENABLE  out  1  access phase
PWRITE  out  1  bus direction
PWDATA_BUS  out  DATA_W  bus write data
PRDATA  in  NUM_SLV*DATA_W  slave read data, slave i at [i*DATA_W +: DATA_W]
PREADY  in  NUM_SLV  slave ready
PSLVERR_S  in  NUM_SLV  slave error

Behaviour:
- Reset: PRESETn sampled low at posedge -> state IDLE. All outputs 0 except cmd_ready=1 after release. Applies mid-transfer: in-flight transfer dropped, no done pulse.
- States: IDLE, SETUP, ACCESS, ERR.
- Accept = TRANSFER & cmd_ready. cmd_ready=1 in IDLE, and in ACCESS in the cycle the selected PREADY=1. 0 otherwise.
- On accept: latch dir, addr (PRADDR if read else PWADDR) and PWDATA.
  - Decoded select < NUM_SLV -> SETUP.
  - Decoded select >= NUM_SLV -> ERR. No PSEL asserted.
- SETUP (1 cycle): PSEL[sel]=1, PENABLE=0, PADDR/PWRITE/PWDATA_BUS valid -> ACCESS.
- ACCESS: PSEL[sel]=1, PENABLE=1. Bus signals held stable. Wait while PREADY[sel]=0.
- Completion, at the posedge with PREADY[sel]=1:
  - Next cycle: done=1, PSLVERR=PSLVERR_S[sel].
  - Read with no error: DATA_OUT=PRDATA[sel]. Write, or read with error: DATA_OUT unchanged.
  - Next state: SETUP if a new command is accepted in the same cycle (back-to-back; PENABLE drops, PSEL follows the new sel), else IDLE with PSEL=0, PENABLE=0.
- ERR (1 cycle): done=1, PSLVERR=1, DATA_OUT unchanged -> IDLE.
- Minimum latency: accept at cycle n, done at cycle n+3 with zero wait states. Each wait state adds 1 cycle.
- PSLVERR and DATA_OUT hold until the next completion. done is 0 otherwise.
- TRANSFER while cmd_ready=0: ignored, no queuing. The requester holds the command.
- PREADY/PSLVERR_S of unselected slaves: ignored.

Optional Feature:
APB_TIMEOUT_EN
- Defined: a wait counter counts ACCESS cycles with PREADY[sel]=0. After TIMEOUT such cycles the transfer terminates as an error:
  - PSEL=0, PENABLE=0.
  - done=1 and PSLVERR=1 the next cycle; DATA_OUT unchanged.
  - Next state IDLE. The counter clears on every SETUP.
- Undefined: no counter. ACCESS waits indefinitely; TIMEOUT unused.

Test Plan:
- Write then read, NUM_SLV=2, slave 0, zero wait: write 0x0A5 data 0x3C, then read 0x0A5 -> PSEL=01. done at accept+3. DATA_OUT=0x3C, PSLVERR=0.
- Read slave 1 (PRADDR=0x1F0) with PREADY low 3 cycles, PRDATA=0x5A -> PENABLE high 4 cycles, done at accept+6, DATA_OUT=0x5A.
- Slave PSLVERR_S=1 on read of 0x010, PRDATA=0xFF -> PSLVERR=1, DATA_OUT keeps previous 0x5A. The next good transfer clears PSLVERR.
- NUM_SLV=3, ADDR_W=9, read address 0x1C0 (sel=3) -> no PSEL, done+PSLVERR=1 at accept+2.
- Back-to-back: TRANSFER held for 3 writes -> PSEL continuous, PENABLE toggles 0/1, three done pulses 2 cycles apart. Separately: PRESETn low during ACCESS -> all bus outputs 0 next cycle, no done.
- APB_TIMEOUT_EN, TIMEOUT=4, PREADY stuck 0 -> termination after 4 wait cycles, done+PSLVERR=1, state returns to IDLE.

Source files
------------

// File: rtl/apb_master_mslv_if.sv
// apb_master_mslv_if: APB3 bus bundle between the bridge (master) and its slaves
interface apb_master_mslv_if #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int NUM_SLV = 2
);
    logic [ADDR_W-1:0]         PADDR;
    logic [NUM_SLV-1:0]        PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [DATA_W-1:0]         PWDATA_BUS;
    logic [NUM_SLV*DATA_W-1:0] PRDATA;
    logic [NUM_SLV-1:0]        PREADY;
    logic [NUM_SLV-1:0]        PSLVERR_S;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA_BUS,
        input  PRDATA, PREADY, PSLVERR_S
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA_BUS,
        output PRDATA, PREADY, PSLVERR_S
    );
endinterface

// File: rtl/apb_master_mslv.sv
// apb_master_mslv: APB3 master bridge to NUM_SLV address-decoded slaves; APB_TIMEOUT_EN adds an ACCESS wait limit
module apb_master_mslv #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int NUM_SLV = 2,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              PRESETn,
    input  logic              TRANSFER,
    input  logic              READ_WRITE,
    input  logic [ADDR_W-1:0] PWADDR,
    input  logic [ADDR_W-1:0] PRADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic              cmd_ready,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              PSLVERR,
    output logic              done,
    apb_master_mslv_if.master bus
);
    localparam int SEL_W = NUM_SLV > 1 ? $clog2(NUM_SLV) : 1;
    localparam logic [SEL_W:0] NSLV = NUM_SLV[SEL_W:0];
    localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, ERR = 2'd3;

    logic [1:0]         state;
    logic [ADDR_W-1:0]  addr;
    logic [ADDR_W-1:0]  cmd_addr;
    logic [SEL_W-1:0]   sel;
    logic [SEL_W-1:0]   cmd_sel;
    logic [DATA_W-1:0]  wdata;
    logic [DATA_W-1:0]  rdata;
    logic [NUM_SLV-1:0] psel;
    logic               write;
    logic               rdy;
    logic               serr;
    logic               accept;
    logic               tmo;

    assign sel            = addr[ADDR_W-1 -: SEL_W];
    assign cmd_addr       = READ_WRITE ? PRADDR : PWADDR;
    assign cmd_sel        = cmd_addr[ADDR_W-1 -: SEL_W];
    assign cmd_ready      = state == IDLE || (state == ACCESS && rdy);
    assign accept         = TRANSFER && cmd_ready;
    assign bus.PADDR      = addr;
    assign bus.PWRITE     = write;
    assign bus.PWDATA_BUS = wdata;
    assign bus.PENABLE    = state == ACCESS;
    assign bus.PSEL       = psel;

    // Pick the addressed slave's response and drive its select during SETUP/ACCESS
    always_comb begin
        rdata = '0;
        rdy   = 1'b0;
        serr  = 1'b0;
        psel  = '0;
        for (int i = 0; i < NUM_SLV; i++)
            if (sel == i[SEL_W-1:0]) begin
                rdata   = bus.PRDATA[i*DATA_W +: DATA_W];
                rdy     = bus.PREADY[i];
                serr    = bus.PSLVERR_S[i];
                psel[i] = state == SETUP || state == ACCESS;
            end
    end

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;

    assign tmo = state == ACCESS && !rdy && cnt == CNT_W'(TIMEOUT - 1);

    // Count unanswered ACCESS cycles; restarts with every SETUP
    always_ff @(posedge clk)
        if (!PRESETn || state == SETUP)
            cnt <= '0;
        else if (state == ACCESS && !rdy)
            cnt <= cnt + 1'b1;
`else
    assign tmo = 1'b0;
`endif

    // Accept and decode commands, step through the APB phases, report completion status
    always_ff @(posedge clk)
        if (!PRESETn) begin
            state    <= IDLE;
            addr     <= '0;
            write    <= 1'b0;
            wdata    <= '0;
            DATA_OUT <= '0;
            PSLVERR  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= (state == ACCESS && (rdy || tmo)) || state == ERR;
            if (state == ERR || tmo)
                PSLVERR <= 1'b1;
            else if (state == ACCESS && rdy) begin
                PSLVERR <= serr;
                if (!write && !serr)
                    DATA_OUT <= rdata;
            end
            if (accept) begin
                addr  <= cmd_addr;
                write <= !READ_WRITE;
                wdata <= PWDATA;
                state <= {1'b0, cmd_sel} < NSLV ? SETUP : ERR;
            end else if (state == SETUP)
                state <= ACCESS;
            else if (state == ERR || tmo || (state == ACCESS && rdy))
                state <= IDLE;
        end
endmodule

// File: tb/tb_apb_master_mslv.sv
// tb_apb_master_mslv: directed + randomized checks of the APB bridge against a transfer-level model (APB_TIMEOUT_EN adds the timeout steps)
`define C(o, e, t) chk(32'(o), 32'(e), t)
module tb_apb_master_mslv;
    logic       clk = 1'b0;
    logic       rstn;
    logic       tr, rw, rdy, dn, perr;
    logic [8:0] wa, ra;
    logic [7:0] wd, dout;
    logic       btr, brw, brdy, bdn, bperr;
    logic [8:0] bwa, bra;
    logic [7:0] bwd, bdout;
    logic [7:0] mem [512];
    logic [7:0] exp_dout;
    logic       exp_err;
    logic       prev_dn = 1'b0;
    int         checks = 0;
    int         errors = 0;

    apb_master_mslv_if #(.ADDR_W(9), .DATA_W(8), .NUM_SLV(2)) ba ();
    apb_master_mslv_if #(.ADDR_W(9), .DATA_W(8), .NUM_SLV(3)) bb ();

    apb_master_mslv #(.ADDR_W(9), .DATA_W(8), .NUM_SLV(2), .TIMEOUT(4)) ua (
        .clk(clk), .PRESETn(rstn), .TRANSFER(tr), .READ_WRITE(rw), .PWADDR(wa), .PRADDR(ra),
        .PWDATA(wd), .cmd_ready(rdy), .DATA_OUT(dout), .PSLVERR(perr), .done(dn), .bus(ba)
    );

    apb_master_mslv #(.ADDR_W(9), .DATA_W(8), .NUM_SLV(3), .TIMEOUT(4)) ub (
        .clk(clk), .PRESETn(rstn), .TRANSFER(btr), .READ_WRITE(brw), .PWADDR(bwa), .PRADDR(bra),
        .PWDATA(bwd), .cmd_ready(brdy), .DATA_OUT(bdout), .PSLVERR(bperr), .done(bdn), .bus(bb)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        checks++;
        if (ba.PENABLE === 1'b1 && ba.PSEL === 2'b00) begin
            errors++;
            $error("FAIL mon_penable_without_psel");
        end
        if (dn === 1'b1 && prev_dn === 1'b1) begin
            errors++;
            $error("FAIL mon_done_not_pulse");
        end
        prev_dn <= dn;
    end

    task automatic chk(input logic [31:0] o, input logic [31:0] e, input string t);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", t, o, e);
        end
    endtask

    task automatic xfer(input logic r, input logic [8:0] a, input logic [7:0] d, input int w, input logic e);
        logic [1:0] oh;
        logic [7:0] rv;
        int s;
        s  = 32'(a[8]);
        oh = 2'b01 << s;
        rv = mem[a];
        @(negedge clk);
        tr = 1'b1;
        rw = r;
        wd = d;
        wa = r ? 9'($urandom) : a;
        ra = r ? a : 9'($urandom);
        ba.PREADY = 2'b00;
        #1 `C(rdy, 1, "idle_ready");
        @(negedge clk);
        tr = 1'b0;
        rw = 1'($urandom);
        wa = 9'($urandom);
        ra = 9'($urandom);
        wd = 8'($urandom);
        #1 `C(ba.PSEL, oh, "setup_psel");
        `C(ba.PENABLE, 0, "setup_penable");
        `C(ba.PADDR, a, "setup_paddr");
        `C(ba.PWRITE, !r, "setup_pwrite");
        `C(rdy, 0, "setup_ready");
        if (!r) `C(ba.PWDATA_BUS, d, "setup_pwdata");
        for (int k = 0; k <= w; k++) begin
            @(negedge clk);
            ba.PREADY = (2'($urandom) & ~oh) | (k == w ? oh : 2'b00);
            ba.PRDATA = 16'($urandom);
            ba.PRDATA[s*8 +: 8] = rv;
            ba.PSLVERR_S = 2'($urandom);
            ba.PSLVERR_S[s] = e;
            #1 `C(ba.PSEL, oh, "access_psel");
            `C(ba.PENABLE, 1, "access_penable");
            `C(ba.PADDR, a, "access_paddr");
            `C(rdy, k == w, "access_ready");
            `C(dn, 0, "access_done");
            if (!r) `C(ba.PWDATA_BUS, d, "access_pwdata");
        end
        @(negedge clk);
        ba.PREADY = 2'b00;
        if (r && !e) exp_dout = rv;
        if (!r && !e) mem[a] = d;
        exp_err = e;
        #1 `C(dn, 1, "done");
        `C(perr, exp_err, "pslverr");
        `C(dout, exp_dout, "data_out");
        `C(ba.PSEL, 0, "idle_psel");
        `C(ba.PENABLE, 0, "idle_penable");
        `C(rdy, 1, "done_ready");
        @(negedge clk);
        #1 `C(dn, 0, "done_pulse");
    endtask

    task automatic b2b();
        logic [8:0] a [3];
        logic [7:0] d [3];
        logic [1:0] o [3];
        for (int t = 0; t < 3; t++) begin
            a[t] = 9'($urandom);
            d[t] = 8'($urandom);
            o[t] = 2'b01 << a[t][8];
        end
        @(negedge clk);
        tr = 1'b1;
        rw = 1'b0;
        wa = a[0];
        wd = d[0];
        ra = 9'($urandom);
        ba.PSLVERR_S = 2'b00;
        #1 `C(rdy, 1, "b2b_idle_ready");
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            ba.PREADY = 2'b00;
            if (t < 2) begin
                wa = a[t+1];
                wd = d[t+1];
            end else tr = 1'b0;
            #1 `C(ba.PSEL, o[t], "b2b_setup_psel");
            `C(ba.PENABLE, 0, "b2b_setup_penable");
            `C(ba.PADDR, a[t], "b2b_setup_paddr");
            `C(ba.PWDATA_BUS, d[t], "b2b_setup_pwdata");
            `C(dn, t > 0, "b2b_setup_done");
            `C(rdy, 0, "b2b_setup_ready");
            @(negedge clk);
            ba.PREADY = o[t];
            #1 `C(ba.PSEL, o[t], "b2b_access_psel");
            `C(ba.PENABLE, 1, "b2b_access_penable");
            `C(rdy, 1, "b2b_access_ready");
            `C(dn, 0, "b2b_access_done");
            mem[a[t]] = d[t];
        end
        @(negedge clk);
        ba.PREADY = 2'b00;
        exp_err = 1'b0;
        #1 `C(dn, 1, "b2b_last_done");
        `C(ba.PSEL, 0, "b2b_idle_psel");
        `C(perr, 0, "b2b_pslverr");
        `C(dout, exp_dout, "b2b_data_out");
    endtask

    initial begin
        rstn = 1'b0;
        {tr, rw, wa, ra, wd} = '0;
        {btr, brw, bwa, bra, bwd} = '0;
        ba.PRDATA = '0;
        ba.PREADY = '0;
        ba.PSLVERR_S = '0;
        bb.PRDATA = '0;
        bb.PREADY = '0;
        bb.PSLVERR_S = '0;
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        `C(dout, 0, "rst_data_out");
        `C(perr, 0, "rst_pslverr");
        `C(dn, 0, "rst_done");
        `C(ba.PSEL, 0, "rst_psel");
        `C(ba.PENABLE, 0, "rst_penable");
        `C(ba.PADDR, 0, "rst_paddr");
        `C(ba.PWRITE, 0, "rst_pwrite");
        rstn = 1'b1;
        exp_dout = 8'h00;
        exp_err = 1'b0;
        #1 `C(rdy, 1, "rst_ready");
        xfer(1'b0, 9'h0A5, 8'h3C, 0, 1'b0);
        xfer(1'b1, 9'h0A5, 8'h00, 0, 1'b0);
        `C(dout, 8'h3C, "wr_rd_data");
        mem[9'h1F0] = 8'h5A;
        xfer(1'b1, 9'h1F0, 8'h00, 3, 1'b0);
        `C(dout, 8'h5A, "wait_rd_data");
        mem[9'h010] = 8'hFF;
        xfer(1'b1, 9'h010, 8'h00, 1, 1'b1);
        `C(dout, 8'h5A, "err_rd_keeps");
        xfer(1'b0, 9'h111, 8'h77, 0, 1'b0);
        `C(perr, 0, "err_cleared");
        repeat (24)
            xfer(1'($urandom), 9'($urandom), 8'($urandom), int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
        b2b();
        @(negedge clk);
        tr = 1'b1;
        rw = 1'b1;
        ra = 9'h033;
        ba.PREADY = 2'b00;
        @(negedge clk);
        tr = 1'b0;
        @(negedge clk);
        #1 `C(ba.PENABLE, 1, "pre_rst_access");
        ba.PREADY = 2'b11;
        rstn = 1'b0;
        @(negedge clk);
        #1 `C(ba.PSEL, 0, "midrst_psel");
        `C(ba.PENABLE, 0, "midrst_penable");
        `C(ba.PADDR, 0, "midrst_paddr");
        `C(ba.PWRITE, 0, "midrst_pwrite");
        `C(ba.PWDATA_BUS, 0, "midrst_pwdata");
        `C(dn, 0, "midrst_done");
        `C(dout, 0, "midrst_data_out");
        `C(perr, 0, "midrst_pslverr");
        rstn = 1'b1;
        ba.PREADY = 2'b00;
        exp_dout = 8'h00;
        exp_err = 1'b0;
        @(negedge clk);
        #1 `C(dn, 0, "midrst_no_done");
        `C(rdy, 1, "midrst_ready");
        xfer(1'b1, 9'h0A5, 8'h00, 2, 1'b0);
        @(negedge clk);
        btr = 1'b1;
        brw = 1'b1;
        bra = 9'h140;
        bwa = 9'h1C0;
        #1 `C(brdy, 1, "b_idle_ready");
        @(negedge clk);
        btr = 1'b0;
        #1 `C(bb.PSEL, 3'b100, "b_setup_psel");
        @(negedge clk);
        bb.PREADY = 3'b100;
        bb.PRDATA = 24'hC32211;
        bb.PSLVERR_S = 3'b011;
        #1 `C(bb.PENABLE, 1, "b_access_penable");
        `C(brdy, 1, "b_access_ready");
        @(negedge clk);
        bb.PREADY = 3'b000;
        #1 `C(bdn, 1, "b_done");
        `C(bdout, 8'hC3, "b_data_out");
        `C(bperr, 0, "b_pslverr");
        @(negedge clk);
        btr = 1'b1;
        brw = 1'b1;
        bra = 9'h1C0;
        bwa = 9'h000;
        #1 `C(brdy, 1, "b_err_idle_ready");
        @(negedge clk);
        btr = 1'b0;
        bb.PREADY = 3'b111;
        #1 `C(bb.PSEL, 0, "b_err_psel");
        `C(bb.PENABLE, 0, "b_err_penable");
        `C(bdn, 0, "b_err_early_done");
        `C(brdy, 0, "b_err_ready");
        @(negedge clk);
        bb.PREADY = 3'b000;
        #1 `C(bdn, 1, "b_err_done");
        `C(bperr, 1, "b_err_pslverr");
        `C(bdout, 8'hC3, "b_err_data_keeps");
        `C(bb.PSEL, 0, "b_err_idle_psel");
        `C(brdy, 1, "b_err_idle_ready");
        @(negedge clk);
        #1 `C(bdn, 0, "b_err_done_pulse");
`ifdef APB_TIMEOUT_EN
        @(negedge clk);
        tr = 1'b1;
        rw = 1'b1;
        ra = 9'h044;
        ba.PREADY = 2'b00;
        #1 `C(rdy, 1, "tmo_idle_ready");
        @(negedge clk);
        tr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ba.PREADY = 2'b10;
            #1 `C(ba.PENABLE, 1, "tmo_wait_penable");
            `C(rdy, 0, "tmo_wait_ready");
            `C(dn, 0, "tmo_wait_done");
        end
        @(negedge clk);
        ba.PREADY = 2'b00;
        exp_err = 1'b1;
        #1 `C(dn, 1, "tmo_done");
        `C(perr, 1, "tmo_pslverr");
        `C(dout, exp_dout, "tmo_data_keeps");
        `C(ba.PSEL, 0, "tmo_psel");
        `C(ba.PENABLE, 0, "tmo_penable");
        `C(rdy, 1, "tmo_ready");
        @(negedge clk);
        #1 `C(dn, 0, "tmo_done_pulse");
        xfer(1'b1, 9'h044, 8'h00, 2, 1'b0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
